// File: rtl/uart_rx_buf_ctrl_pkg.sv
// Shared UART receive-buffer definitions: trigger encodings, entry layout, timeout scaling.
package uart_rx_buf_ctrl_pkg;

   typedef enum logic [1:0] {
      TRIG_1  = 2'b00,
      TRIG_4  = 2'b01,
      TRIG_8  = 2'b10,
      TRIG_14 = 2'b11
   } trig_sel_e;

   localparam int ENTRY_W   = 11;
   localparam int DATA_LSB  = 0;
   localparam int DATA_MSB  = 7;
   localparam int PE_BIT    = 8;
   localparam int FE_BIT    = 9;
   localparam int BI_BIT    = 10;
   localparam int TOUT_MULT = 64;
   localparam int TOUT_W    = 10;
   localparam int LVL_W     = 7;

   // Trigger level, clamped so shallow FIFOs can still raise the interrupt.
   function automatic logic [LVL_W-1:0] trig_level(input trig_sel_e sel, input int depth);
      int lvl;
      case (sel)
         TRIG_1:  lvl = 1;
         TRIG_4:  lvl = 4;
         TRIG_8:  lvl = 8;
         default: lvl = 14;
      endcase
      if (lvl > depth) lvl = depth;
      return LVL_W'(lvl);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; head visible combinationally, push accepted when full only with a same-cycle pop.
module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 11
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   always_comb begin
      pop_ok  = pop_i & ~empty_o & ~clr_i;
      push_ok = push_i & (~full_o | pop_ok) & ~clr_i;
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/uart_rx_buf_ctrl.sv
// UART receive buffer control: edge-detected push, overrun/error tracking, character timeout.
// Interrupt outputs are registered (one clk); pushes into a full FIFO without a pop are dropped as overruns.
module uart_rx_buf_ctrl
   import uart_rx_buf_ctrl_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    brcx16_i,
   input  logic [3:0]              num_bits_i,
   input  logic                    parity_en_i,
   input  logic                    rx_d_rdy_i,
   input  logic [7:0]              rx_d_i,
   input  logic                    rx_pe_i,
   input  logic                    rx_fe_i,
   input  logic                    rx_bi_i,
   input  logic                    fifo_clr_i,
   input  logic [1:0]              trig_sel_i,
   input  logic                    rd_i,
   input  logic                    lsr_rd_i,
   output logic [7:0]              rd_data_o,
   output logic [2:0]              rd_err_o,
   output logic                    empty_o,
   output logic                    full_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    ovr_err_o,
   output logic                    err_in_fifo_o,
   output logic                    rx_itr_o,
   output logic                    ls_itr_o
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic               rdy_q, arm_q, ovr_q, ovr_d, tout_q, tout_d, rx_itr_q, ls_itr_q;
   logic [CW-1:0]      err_cnt_q, err_cnt_d;
   logic [TOUT_W-1:0]  tcnt_q, tcnt_d, tout_thr;
   logic               push_req, pop_req, push_ok, overrun, entry_err, head_err, tzero;
   logic [ENTRY_W-1:0] wdata, head;

   always_comb begin
      wdata                    = '0;
      wdata[DATA_MSB:DATA_LSB] = rx_d_i;
      wdata[PE_BIT]            = rx_pe_i;
      wdata[FE_BIT]            = rx_fe_i;
      wdata[BI_BIT]            = rx_bi_i;

      // arm_q masks the first clk after reset so a level already high then is not an edge.
      push_req  = arm_q & rx_d_rdy_i & ~rdy_q & ~fifo_clr_i;
      pop_req   = rd_i & ~empty_o & ~fifo_clr_i;
      push_ok   = push_req & (~full_o | pop_req);
      overrun   = push_req & full_o & ~pop_req;
      entry_err = rx_pe_i | rx_fe_i | rx_bi_i;
      head_err  = |rd_err_o;

      ovr_d = ovr_q;
      if (overrun)       ovr_d = 1'b1;
      else if (lsr_rd_i) ovr_d = 1'b0;

      err_cnt_d = err_cnt_q + CW'(push_ok & entry_err) - CW'(pop_req & head_err);

      tout_thr = TOUT_W'(TOUT_MULT * (2 + int'(num_bits_i) + int'(parity_en_i)));
      tzero    = push_req | pop_req | fifo_clr_i | empty_o;
      tcnt_d   = tcnt_q;
      if (tzero)                               tcnt_d = '0;
      else if (brcx16_i && tcnt_q < tout_thr)  tcnt_d = tcnt_q + 1'b1;
      tout_d = ~tzero & (tcnt_d >= tout_thr);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdy_q     <= 1'b0;
         arm_q     <= 1'b0;
         ovr_q     <= 1'b0;
         err_cnt_q <= '0;
         tcnt_q    <= '0;
         tout_q    <= 1'b0;
         rx_itr_q  <= 1'b0;
         ls_itr_q  <= 1'b0;
      end else begin
         rdy_q     <= rx_d_rdy_i;
         arm_q     <= 1'b1;
         ovr_q     <= ovr_d;
         err_cnt_q <= fifo_clr_i ? '0 : err_cnt_d;
         tcnt_q    <= tcnt_d;
         tout_q    <= tout_d;
         rx_itr_q  <= (LVL_W'(count_o) >= trig_level(trig_sel_e'(trig_sel_i), DEPTH)) | tout_q;
         ls_itr_q  <= ovr_q | (~empty_o & head_err);
      end
   end

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (fifo_clr_i),
      .push_i  (push_req),
      .pop_i   (pop_req),
      .wdata_i (wdata),
      .rdata_o (head),
      .empty_o (empty_o),
      .full_o  (full_o),
      .count_o (count_o)
   );

   assign rd_data_o     = head[DATA_MSB:DATA_LSB];
   assign rd_err_o      = head[BI_BIT:PE_BIT];
   assign ovr_err_o     = ovr_q;
   assign err_in_fifo_o = |err_cnt_q;
   assign rx_itr_o      = rx_itr_q;
   assign ls_itr_o      = ls_itr_q;

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Directed bench for uart_rx_buf_ctrl with a scoreboard of stored entries.
module tb_uart_rx_buf_ctrl;
   localparam int DEPTH = 16;

   logic       clk_i = 1'b0;
   logic       rst_i, brcx16_i, parity_en_i, rx_d_rdy_i;
   logic [3:0] num_bits_i;
   logic [7:0] rx_d_i;
   logic       rx_pe_i, rx_fe_i, rx_bi_i, fifo_clr_i, rd_i, lsr_rd_i;
   logic [1:0] trig_sel_i;
   logic [7:0] rd_data_o;
   logic [2:0] rd_err_o;
   logic       empty_o, full_o, ovr_err_o, err_in_fifo_o, rx_itr_o, ls_itr_o;
   logic [$clog2(DEPTH):0] count_o;

   logic [10:0] sb[$];
   logic [10:0] exp_e;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   uart_rx_buf_ctrl #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .brcx16_i(brcx16_i), .num_bits_i(num_bits_i),
      .parity_en_i(parity_en_i), .rx_d_rdy_i(rx_d_rdy_i), .rx_d_i(rx_d_i),
      .rx_pe_i(rx_pe_i), .rx_fe_i(rx_fe_i), .rx_bi_i(rx_bi_i), .fifo_clr_i(fifo_clr_i),
      .trig_sel_i(trig_sel_i), .rd_i(rd_i), .lsr_rd_i(lsr_rd_i), .rd_data_o(rd_data_o),
      .rd_err_o(rd_err_o), .empty_o(empty_o), .full_o(full_o), .count_o(count_o),
      .ovr_err_o(ovr_err_o), .err_in_fifo_o(err_in_fifo_o), .rx_itr_o(rx_itr_o),
      .ls_itr_o(ls_itr_o)
   );

   task automatic clk1();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic pe, input logic fe, input logic bi,
                       input bit store);
      rx_d_i = d; rx_pe_i = pe; rx_fe_i = fe; rx_bi_i = bi;
      rx_d_rdy_i = 1'b1;
      clk1();
      rx_d_rdy_i = 1'b0;
      clk1();
      if (store) sb.push_back({bi, fe, pe, d});
   endtask

   task automatic pop_chk(input string tag);
      chk({tag, "_nonempty"}, 32'(empty_o), 32'd0);
      if (sb.size() != 0) begin
         exp_e = sb.pop_front();
         chk({tag, "_head"}, 32'({rd_err_o, rd_data_o}), 32'(exp_e));
      end
      rd_i = 1'b1;
      clk1();
      rd_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; brcx16_i = 1'b0; num_bits_i = 4'd8; parity_en_i = 1'b0;
      rx_d_rdy_i = 1'b1; rx_d_i = 8'h00; rx_pe_i = 1'b0; rx_fe_i = 1'b0; rx_bi_i = 1'b0;
      fifo_clr_i = 1'b0; trig_sel_i = 2'b01; rd_i = 1'b0; lsr_rd_i = 1'b0;

      // Reset with rx_d_rdy already high: release must not push.
      repeat (3) clk1();
      rst_i = 1'b0;
      repeat (3) clk1();
      chk("rst_empty", 32'(empty_o), 32'd1);
      chk("rst_full", 32'(full_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_ovr", 32'(ovr_err_o), 32'd0);
      chk("rst_errin", 32'(err_in_fifo_o), 32'd0);
      chk("rst_rxitr", 32'(rx_itr_o), 32'd0);
      chk("rst_lsitr", 32'(ls_itr_o), 32'd0);
      rx_d_rdy_i = 1'b0;
      clk1();

      // Trigger level 4.
      send(8'h41, 0, 0, 0, 1);
      send(8'h42, 0, 0, 0, 1);
      send(8'h43, 0, 0, 0, 1);
      chk("trig_count3", 32'(count_o), 32'd3);
      chk("trig_itr3", 32'(rx_itr_o), 32'd0);
      rx_d_i = 8'h44; rx_d_rdy_i = 1'b1;
      clk1();
      sb.push_back({3'b000, 8'h44});
      chk("trig_count4", 32'(count_o), 32'd4);
      chk("trig_itr_lat", 32'(rx_itr_o), 32'd0);
      rx_d_rdy_i = 1'b0;
      clk1();
      chk("trig_itr4", 32'(rx_itr_o), 32'd1);
      for (int i = 0; i < 4; i++) pop_chk("trig_pop");
      chk("trig_drained", 32'(empty_o), 32'd1);

      // Error tracking.
      send(8'h10, 0, 1, 0, 1);
      send(8'h11, 0, 0, 0, 1);
      chk("err_lsitr", 32'(ls_itr_o), 32'd1);
      chk("err_inf", 32'(err_in_fifo_o), 32'd1);
      pop_chk("err_pop1");
      chk("err_inf_clr", 32'(err_in_fifo_o), 32'd0);
      clk1();
      chk("err_lsitr_clr", 32'(ls_itr_o), 32'd0);
      pop_chk("err_pop2");

      // Fill, overrun, clear by line-status read.
      for (int i = 0; i < DEPTH; i++) send(8'h60 + 8'(i), 0, 0, 0, 1);
      chk("fill_full", 32'(full_o), 32'd1);
      chk("fill_count", 32'(count_o), 32'd16);
      send(8'h55, 0, 0, 0, 0);
      chk("ovr_set", 32'(ovr_err_o), 32'd1);
      chk("ovr_count", 32'(count_o), 32'd16);
      chk("ovr_head", 32'({rd_err_o, rd_data_o}), 32'(sb[0]));
      lsr_rd_i = 1'b1;
      clk1();
      lsr_rd_i = 1'b0;
      chk("ovr_clr", 32'(ovr_err_o), 32'd0);

      // Full with same-clk pop and push.
      chk("fp_head", 32'({rd_err_o, rd_data_o}), 32'(sb[0]));
      rd_i = 1'b1; rx_d_i = 8'hA5; rx_d_rdy_i = 1'b1;
      clk1();
      rd_i = 1'b0; rx_d_rdy_i = 1'b0;
      void'(sb.pop_front());
      sb.push_back({3'b000, 8'hA5});
      clk1();
      chk("fp_count", 32'(count_o), 32'd16);
      chk("fp_noovr", 32'(ovr_err_o), 32'd0);
      for (int i = 0; i < DEPTH; i++) pop_chk("fp_drain");
      chk("drain_empty", 32'(empty_o), 32'd1);
      rd_i = 1'b1;
      clk1();
      rd_i = 1'b0;
      chk("rd_empty_count", 32'(count_o), 32'd0);
      chk("rd_empty_flag", 32'(empty_o), 32'd1);

      // Timeout: 8 data bits + parity -> 704 ticks.
      num_bits_i = 4'd8; parity_en_i = 1'b1;
      send(8'h77, 1, 0, 0, 1);
      for (int i = 0; i < 703; i++) begin
         brcx16_i = 1'b1; clk1();
         brcx16_i = 1'b0; clk1();
      end
      chk("tout_703", 32'(rx_itr_o), 32'd0);
      brcx16_i = 1'b1;
      clk1();
      brcx16_i = 1'b0;
      chk("tout_lat", 32'(rx_itr_o), 32'd0);
      clk1();
      chk("tout_704", 32'(rx_itr_o), 32'd1);
      lsr_rd_i = 1'b1;
      pop_chk("tout_pop");
      lsr_rd_i = 1'b0;
      clk1();
      chk("tout_clr", 32'(rx_itr_o), 32'd0);

      // Held level gives one push.
      rx_d_i = 8'h33; rx_pe_i = 1'b0; rx_d_rdy_i = 1'b1;
      repeat (16) clk1();
      sb.push_back({3'b000, 8'h33});
      rx_d_rdy_i = 1'b0;
      clk1();
      chk("held_count", 32'(count_o), 32'd1);
      pop_chk("held_pop");

      // Clear coincident with a push.
      send(8'h01, 0, 1, 0, 0);
      rx_d_i = 8'h99; rx_d_rdy_i = 1'b1; fifo_clr_i = 1'b1;
      clk1();
      rx_d_rdy_i = 1'b0; fifo_clr_i = 1'b0;
      clk1();
      chk("clr_empty", 32'(empty_o), 32'd1);
      chk("clr_count", 32'(count_o), 32'd0);
      chk("clr_ovr", 32'(ovr_err_o), 32'd0);
      chk("clr_errin", 32'(err_in_fifo_o), 32'd0);

      // Reset mid-stream discards everything.
      send(8'h5A, 0, 0, 1, 0);
      rst_i = 1'b1;
      clk1();
      rst_i = 1'b0;
      clk1();
      chk("mrst_empty", 32'(empty_o), 32'd1);
      chk("mrst_errin", 32'(err_in_fifo_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
